// File: rtl/zc_pkg.sv
// zc_pkg: shared constants, state/kind enums and small decode helpers for the
// DM-RS base-sequence phase generator.
//   RECIP31       Q0.20 approximation of 1/31
//   state_t       top-level FSM states
//   kind_t        sequence family chosen from the latched length
//   phi_decode    2-bit phi table code -> signed phi
//   len_supported true for 6/12/18/24/30 and any length >= 36
package zc_pkg;

    localparam int                    RECIP_FRAC = 20;
    localparam logic [RECIP_FRAC-1:0] RECIP31    = 20'h08421;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QCALC,
        S_SCALC,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_TAB,
        K_L30,
        K_ZC
    } kind_t;

    function automatic logic signed [3:0] phi_decode(input logic [1:0] code);
        case (code)
            2'b00:   return 4'sd1;
            2'b01:   return 4'sd3;
            2'b10:   return -4'sd3;
            default: return -4'sd1;
        endcase
    endfunction

    function automatic logic len_supported(input int unsigned len);
        return (len == 6) || (len == 12) || (len == 18) || (len == 24) ||
               (len == 30) || (len >= 36);
    endfunction

endpackage

// File: rtl/zc_q_calc.sv
// zc_q_calc: registered ZC root q from group number u, base-sequence number v
// and N_zc.
//   qbar = N*(u+1)/31 in Q10.5 (truncated), q = round(qbar) +/- v, where the
//   sign of the v correction follows the parity of floor(2*qbar).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   i_en        load o_q this cycle
//   i_prime     N_zc
//   i_u, i_v    group / base-sequence number
//   o_q         registered q (one extra bit for the +v case)
module zc_q_calc
    import zc_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [LEN_W-1:0] i_prime,
    input  logic [4:0]       i_u,
    input  logic             i_v,
    output logic [LEN_W:0]   o_q
);
    localparam int PW = LEN_W + 6 + RECIP_FRAC;

    logic [5:0]       w_u1;
    logic [PW-1:0]    w_prod;
    logic [LEN_W+4:0] w_qbar;     // Q10.5
    logic [LEN_W+5:0] w_rsum;
    logic [LEN_W:0]   w_rnd;
    logic [LEN_W:0]   w_q;

    assign w_u1   = {1'b0, i_u} + 6'd1;
    assign w_prod = PW'(i_prime) * PW'(w_u1) * PW'(RECIP31);
    assign w_qbar = (LEN_W+5)'(w_prod >> (RECIP_FRAC - 5));
    assign w_rsum = {1'b0, w_qbar} + (LEN_W+6)'(16);
    assign w_rnd  = (LEN_W+1)'(w_rsum >> 5);
    // Half bit set means floor(2*qbar) is odd: subtract v instead of adding.
    assign w_q    = w_qbar[4] ? w_rnd - (LEN_W+1)'(i_v) : w_rnd + (LEN_W+1)'(i_v);

    always_ff @(posedge clk) begin
        if (reset)     o_q <= '0;
        else if (i_en) o_q <= w_q;
    end

endmodule

// File: rtl/zc_phase_gen.sv
// zc_phase_gen: DM-RS low-PAPR base-sequence phase generator with cyclic-shift
// ramp. One phase word per subcarrier index, valid/ready handshake out.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, abort       command pulse (IDLE only) / return to IDLE
//   mzc, u, v, prime,  configuration, latched on start
//   prime_rec, cs_step
//   phi_code           phi table code for the current idx (table lengths)
//   idx, phase, valid  output sample, ready is the downstream accept
//   busy, done, err    status; err pulses with done for unsupported lengths
module zc_phase_gen
    import zc_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int PHASE_W = 15,
    parameter int STEP_W  = 26,
    parameter int REC_W   = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   mzc,
    input  logic [4:0]         u,
    input  logic               v,
    input  logic [LEN_W-1:0]   prime,
    input  logic [REC_W-1:0]   prime_rec,
    input  logic [PHASE_W-1:0] cs_step,
    input  logic [1:0]         phi_code,
    output logic [LEN_W-1:0]   idx,
    output logic [PHASE_W-1:0] phase,
    output logic               valid,
    input  logic               ready,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int SH  = REC_W - STEP_W;
    localparam int QPW = LEN_W + 1 + REC_W;
    localparam int RSH = STEP_W - PHASE_W;

    state_t             r_state, w_next;
    kind_t              r_kind;
    logic [LEN_W-1:0]   r_mzc, r_prime, r_idx;
    logic [4:0]         r_u;
    logic               r_v, r_err;
    logic [REC_W-1:0]   r_prime_rec;
    logic [PHASE_W-1:0] r_cs_step, r_cs, r_zc;
    logic [STEP_W-1:0]  r_inc, r_step;

    logic               w_latch, w_valid, w_done, w_hs, w_last, w_sup, w_qen;
    logic [LEN_W:0]     w_q;
    logic [5:0]         w_u1;
    logic [STEP_W-1:0]  w_inc, w_inc_zc, w_inc30, w_step_nx;
    logic [PHASE_W-1:0] w_zc_nx, w_phase_tab, w_phase;
    logic signed [3:0]  w_phi;

    // Step (fraction of a turn, Q0.STEP_W) rounded to a PHASE_W phase word.
    function automatic logic [PHASE_W-1:0] f_rnd(input logic [STEP_W-1:0] s);
        logic [STEP_W-1:0] t;
        t = s + (STEP_W'(1) << (RSH - 1));
        return PHASE_W'(t >> RSH);
    endfunction

    assign w_qen = (r_state == S_QCALC);

    zc_q_calc #(.LEN_W(LEN_W)) u_q_calc (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_qen),
        .i_prime (r_prime),
        .i_u     (r_u),
        .i_v     (r_v),
        .o_q     (w_q)
    );

    assign w_sup     = len_supported(32'(r_mzc));
    assign w_u1      = {1'b0, r_u} + 6'd1;
    assign w_inc_zc  = STEP_W'((QPW'(w_q) * QPW'(r_prime_rec) + (QPW'(1) << (SH - 1))) >> SH);
    assign w_inc30   = STEP_W'((STEP_W'(w_u1) * STEP_W'(RECIP31)) << (STEP_W - RECIP_FRAC));
    assign w_inc     = (r_mzc >= LEN_W'(36)) ? w_inc_zc : w_inc30;
    assign w_step_nx = r_step + r_inc;
    assign w_zc_nx   = r_zc + f_rnd(w_step_nx);

    // Table lengths: phase = cs + phi * 1/8 turn, phi taken straight from the input.
    assign w_phi       = phi_decode(phi_code);
    assign w_phase_tab = r_cs + ({{(PHASE_W-4){w_phi[3]}}, w_phi} << (PHASE_W - 3));
    assign w_phase     = (r_kind == K_TAB) ? w_phase_tab : r_cs - r_zc;

    assign w_last = (r_idx == r_mzc - LEN_W'(1));
    assign w_hs   = w_valid & ready;

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  if (start) begin
                         w_next  = S_QCALC;
                         w_latch = 1'b1;
                     end
            S_QCALC: w_next = S_SCALC;
            S_SCALC: w_next = w_sup ? S_RUN : S_DONE;
            S_RUN:   begin
                         w_valid = 1'b1;
                         if (ready && w_last) w_next = S_DONE;
                     end
            S_DONE:  begin
                         w_done = 1'b1;
                         w_next = S_IDLE;
                     end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next  = S_IDLE;
            w_latch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mzc       <= '0;
            r_prime     <= '0;
            r_u         <= '0;
            r_v         <= 1'b0;
            r_prime_rec <= '0;
            r_cs_step   <= '0;
            r_kind      <= K_TAB;
            r_err       <= 1'b0;
            r_inc       <= '0;
            r_idx       <= '0;
            r_step      <= '0;
            r_zc        <= '0;
            r_cs        <= '0;
        end else begin
            if (w_latch) begin
                r_mzc       <= mzc;
                r_prime     <= prime;
                r_u         <= u;
                r_v         <= v;
                r_prime_rec <= prime_rec;
                r_cs_step   <= cs_step;
                r_err       <= 1'b0;
            end
            if (r_state == S_SCALC) begin
                r_inc <= w_inc;
                r_err <= !w_sup;
                r_idx <= '0;
                r_cs  <= '0;
                if (r_mzc >= LEN_W'(36)) begin
                    r_kind <= K_ZC;
                    r_step <= '0;
                    r_zc   <= '0;
                end else if (r_mzc == LEN_W'(30)) begin
                    // Length 30 starts one step in: index 0 already carries inc.
                    r_kind <= K_L30;
                    r_step <= w_inc30;
                    r_zc   <= f_rnd(w_inc30);
                end else begin
                    r_kind <= K_TAB;
                    r_step <= '0;
                    r_zc   <= '0;
                end
            end else if (w_hs) begin
                if (w_last) begin
                    r_idx  <= '0;
                    r_cs   <= '0;
                    r_step <= '0;
                    r_zc   <= '0;
                end else begin
                    r_idx <= r_idx + LEN_W'(1);
                    r_cs  <= r_cs + r_cs_step;
                    // Cyclic extension: the ZC sequence restarts at n = N_zc.
                    if (r_kind == K_ZC && (r_idx + LEN_W'(1)) == r_prime) begin
                        r_step <= '0;
                        r_zc   <= '0;
                    end else begin
                        r_step <= w_step_nx;
                        r_zc   <= w_zc_nx;
                    end
                end
            end
            if (abort) begin
                r_idx  <= '0;
                r_cs   <= '0;
                r_step <= '0;
                r_zc   <= '0;
            end
        end
    end

    assign idx   = r_idx;
    assign phase = (r_state == S_RUN) ? w_phase : '0;
    assign valid = w_valid;
    assign busy  = (r_state != S_IDLE);
    assign done  = w_done;
    assign err   = w_done & r_err;

endmodule

// File: tb/tb_zc_phase_gen.sv
// tb_zc_phase_gen: self-checking bench for zc_phase_gen. A reference model
// computes every expected phase directly from the sequence definitions
// (closed-form step n*inc, sum of rounded steps, n*cs_step), and each run is
// checked sample by sample, including holds under backpressure, latency,
// done/err pulses, abort and reset.
module tb_zc_phase_gen;
    localparam int LEN_W   = 10;
    localparam int PHASE_W = 15;
    localparam int STEP_W  = 26;
    localparam int REC_W   = 30;
    localparam longint SMASK = (64'd1 << STEP_W) - 1;
    localparam longint PMASK = (64'd1 << PHASE_W) - 1;

    logic               clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic               v = 1'b0, ready = 1'b0;
    logic [LEN_W-1:0]   mzc = '0, prime = '0;
    logic [4:0]         u = '0;
    logic [REC_W-1:0]   prime_rec = '0;
    logic [PHASE_W-1:0] cs_step = '0;
    logic [1:0]         phi_code = '0;
    logic [LEN_W-1:0]   idx;
    logic [PHASE_W-1:0] phase;
    logic               valid, busy, done, err;

    int n_chk = 0, n_err = 0, cyc_cnt = 0, last_lat = 0;
    int phi_tab [0:1023];
    int exp_ph  [0:1023];
    int obs_ph  [0:1023];

    zc_phase_gen dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mzc(mzc), .u(u), .v(v), .prime(prime), .prime_rec(prime_rec),
        .cs_step(cs_step), .phi_code(phi_code), .idx(idx), .phase(phase),
        .valid(valid), .ready(ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int prime_below(input int m);
        bit ok;
        for (int p = m - 1; p > 2; p--) begin
            ok = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) ok = 1'b0;
            if (ok) return p;
        end
        return 2;
    endfunction

    function automatic longint recip(input int p);
        return ((64'd1 << REC_W) + longint'(p / 2)) / longint'(p);
    endfunction

    // Fraction of a turn (Q0.26) to nearest phase word, modulo a full turn.
    function automatic longint to_ph(input longint s);
        return ((s + (64'd1 << (STEP_W - PHASE_W - 1))) >> (STEP_W - PHASE_W)) & PMASK;
    endfunction

    task automatic build_model(input int m, input int uu, input int vv, input int pr,
                               input longint rec, input int cs);
        longint qb, r, q, inc, zc, csn;
        int phv, me;
        qb = (longint'(pr) * longint'(uu + 1) * 33825) >> 15;
        r  = (qb + 16) >> 5;
        q  = ((qb >> 4) & 1) != 0 ? r - vv : r + vv;
        if (m >= 36) inc = ((q * rec + 8) >> 4) & SMASK;
        else         inc = ((longint'(uu + 1) * 33825) << 6) & SMASK;
        for (int n = 0; n < m; n++) begin
            csn = (longint'(n) * cs) & PMASK;
            zc  = 0;
            if (m >= 36) begin
                me = (n < pr) ? n : n - pr;
                for (int k = 1; k <= me; k++) zc += to_ph((longint'(k) * inc) & SMASK);
            end else if (m == 30) begin
                for (int k = 0; k <= n; k++) zc += to_ph((longint'(k + 1) * inc) & SMASK);
            end else begin
                case (phi_tab[n])
                    0: phv = 1;
                    1: phv = 3;
                    2: phv = -3;
                    default: phv = -1;
                endcase
                zc = -longint'(phv) * 4096;
            end
            exp_ph[n] = int'((csn - zc) & PMASK);
        end
    endtask

    // rmode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready + stray starts.
    // kill_kind: 0 none, 1 abort, 2 reset, applied when the run reaches kill_at.
    task automatic run_seq(input int m, input int uu, input int vv, input int pr,
                           input longint rec, input int cs, input int rmode,
                           input int kill_at, input int kill_kind);
        int n, iters, t0;
        logic r;
        bit sup;
        sup = (m inside {6, 12, 18, 24, 30}) || (m >= 36);
        if (sup) build_model(m, uu, vv, pr, rec, cs);
        mzc = LEN_W'(m); u = 5'(uu); v = 1'(vv); prime = LEN_W'(pr);
        prime_rec = REC_W'(rec); cs_step = PHASE_W'(cs); ready = 1'b1;
        start = 1'b1; t0 = cyc_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        mzc = LEN_W'($urandom); u = 5'($urandom); v = 1'($urandom);
        prime = LEN_W'($urandom); prime_rec = REC_W'($urandom); cs_step = PHASE_W'($urandom);
        #1;
        chk("q_busy", busy, 1); chk("q_valid", valid, 0);
        @(posedge clk); #2;
        chk("s_valid", valid, 0);
        if (!sup) begin
            @(posedge clk); #2;
            chk("u_done", done, 1); chk("u_err", err, 1); chk("u_valid", valid, 0);
            chk("u_lat", cyc_cnt - t0, 3);
            @(posedge clk); #2;
            chk("u_done2", done, 0); chk("u_err2", err, 0); chk("u_busy", busy, 0);
            chk("u_valid2", valid, 0);
            return;
        end
        @(posedge clk); #1;
        n = 0; iters = 0;
        while (n < m && iters < 4 * m + 20) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (iters % 4 == 0) || (iters % 4 == 3);
                default: r = ($urandom_range(0, 9) < 7);
            endcase
            ready = r; phi_code = 2'(phi_tab[n]);
            start = (rmode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (start) begin
                mzc = LEN_W'($urandom); u = 5'($urandom); prime = LEN_W'($urandom);
            end
            #1;
            chk("valid", valid, 1); chk("idx", idx, n); chk("phase", phase, exp_ph[n]);
            chk("done_low", done, 0);
            if (r) obs_ph[n] = int'(phase);
            if (kill_kind != 0 && n == kill_at) begin
                abort = (kill_kind == 1); reset = (kill_kind == 2);
                @(posedge clk); #1;
                abort = 1'b0; reset = 1'b0; ready = 1'b0;
                #1;
                chk("k_valid", valid, 0); chk("k_busy", busy, 0); chk("k_done", done, 0);
                if (kill_kind == 2) begin
                    chk("k_idx", idx, 0); chk("k_phase", phase, 0); chk("k_err", err, 0);
                end
                @(posedge clk); #2;
                chk("k_done2", done, 0); chk("k_valid2", valid, 0);
                return;
            end
            if (r) n++;
            iters++;
            @(posedge clk); #1;
        end
        if (n < m) chk("timeout", n, m);
        start = 1'b0;
        #1;
        chk("d_valid", valid, 0); chk("done", done, 1); chk("d_err", err, 0);
        last_lat = cyc_cnt - t0;
        chk("d_lat", last_lat, 3 + iters);
        @(posedge clk); #2;
        chk("i_busy", busy, 0); chk("i_done", done, 0);
    endtask

    initial begin
        int tab_exp [0:5];
        int m, pr, kind;
        tab_exp = '{4096, 12288, 20480, 28672, 4096, 12288};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_idx", idx, 0); chk("rst_phase", phase, 0); chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Table length 6 with the phi sequence 00,01,10,11,00,01.
        for (int i = 0; i < 6; i++) phi_tab[i] = i % 4;
        run_seq(6, 3, 0, 5, recip(5), 0, 0, -1, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("tab6_%0d", i), obs_ph[i], tab_exp[i]);

        // ZC length 36, N=31, q=1.
        run_seq(36, 0, 0, 31, recip(31), 0, 0, -1, 0);
        chk("zc36_n0", obs_ph[0], 0);
        chk("zc36_n1", obs_ph[1], 31711);
        chk("zc36_n31", obs_ph[31], 0);
        chk("zc36_lat", last_lat, 39);

        // Same with a cyclic-shift ramp of 0x0800 per index.
        run_seq(36, 0, 0, 31, recip(31), 'h800, 0, -1, 0);
        chk("cs36_n1", obs_ph[1], 991);
        chk("cs36_n31", obs_ph[31], 30720);

        // Backpressure pattern 1,0,0,1 on a ZC run with v=1.
        for (int i = 0; i < 1024; i++) phi_tab[i] = $urandom_range(0, 3);
        run_seq(48, 7, 1, 47, recip(47), 'h123, 1, -1, 0);

        // Unsupported length.
        run_seq(10, 2, 0, 7, recip(7), 5, 0, -1, 0);

        // Abort part way through a run.
        run_seq(48, 11, 0, 47, recip(47), 'h40, 0, 5, 1);

        // start and abort together in IDLE: nothing starts.
        mzc = 36; prime = 31; prime_rec = REC_W'(recip(31)); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        #1;
        chk("sa_busy", busy, 0); chk("sa_valid", valid, 0);
        @(posedge clk); #2;
        chk("sa_busy2", busy, 0); chk("sa_valid2", valid, 0);

        // Reset mid-run, then a normal length-30 run.
        run_seq(48, 20, 1, 47, recip(47), 'h7ff, 0, 7, 2);
        run_seq(30, 4, 0, 29, recip(29), 'h55, 0, -1, 0);

        // Randomized runs across all sequence families.
        repeat (15) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: m = 6;
                1: m = 12;
                2: m = 18;
                3: m = 24;
                4: m = 30;
                default: m = $urandom_range(36, 160);
            endcase
            pr = prime_below(m);
            for (int i = 0; i < m; i++) phi_tab[i] = $urandom_range(0, 3);
            run_seq(m, $urandom_range(0, 29), $urandom_range(0, 1), pr, recip(pr),
                    $urandom_range(0, 32767), 2, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
